// File: rtl/snake_pkg.sv
// Shared types and constants for the snake step controller and the VGA path.
package snake_pkg;
    localparam int COORD_W     = 32;
    localparam int TILE_ORIGIN = 48;   // board origin in pixels
    localparam int TILE_SIZE   = 48;   // tile edge in pixels

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_SCAN,
        ST_COMMIT,
        ST_OVER
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } coord_t;

    // Up/down and left/right differ only in the high bit.
    function automatic dir_t dir_opposite(dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction
endpackage

// File: rtl/snake_next_head.sv
// Combinational next-head tile and wall check.
module snake_next_head
    import snake_pkg::*;
#(
    parameter int GRID_W = 8,
    parameter int GRID_H = 8
) (
    input  coord_t head,
    input  dir_t   dir,
    output coord_t next,
    output logic   out_of_bounds
);
    localparam logic signed [COORD_W:0] ONE   = (COORD_W+1)'(1);
    localparam logic signed [COORD_W:0] X_LIM = (COORD_W+1)'(GRID_W);
    localparam logic signed [COORD_W:0] Y_LIM = (COORD_W+1)'(GRID_H);

    logic signed [COORD_W:0] nx, ny;

    // Step one tile on the direction axis; a one-bit extension keeps -1 visible as negative.
    always_comb begin
        nx = $signed({1'b0, head.x});
        ny = $signed({1'b0, head.y});
        case (dir)
            DIR_UP:    ny = ny - ONE;
            DIR_RIGHT: nx = nx + ONE;
            DIR_DOWN:  ny = ny + ONE;
            default:   nx = nx - ONE;
        endcase
        next.x        = nx[COORD_W-1:0];
        next.y        = ny[COORD_W-1:0];
        out_of_bounds = nx[COORD_W] || (nx >= X_LIM) || ny[COORD_W] || (ny >= Y_LIM);
    end
endmodule

// File: rtl/snake_step_controller.sv
// Snake body sequencer: per-tick head advance, wall check, serial self-collision scan, one-cycle shift commit.
module snake_step_controller
    import snake_pkg::*;
#(
    parameter int MAX_LEN   = 100,
    parameter int GRID_W    = 8,
    parameter int GRID_H    = 8,
    parameter int START_LEN = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         tick,
    input  logic                         dir_valid,
    input  logic [1:0]                   dir,
    input  logic                         grow,
    input  logic                         restart,
    output logic [MAX_LEN*32-1:0]        x_values,
    output logic [MAX_LEN*32-1:0]        y_values,
    output logic [$clog2(MAX_LEN+1)-1:0] length,
    output logic                         busy,
    output logic                         step_done,
    output logic                         game_over
);
    localparam int             LEN_W   = $clog2(MAX_LEN+1);
    localparam logic [LEN_W-1:0] START_L = LEN_W'(START_LEN);
    localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] L_ONE   = LEN_W'(1);

    coord_t [MAX_LEN-1:0] seg;
    coord_t               next_head;
    coord_t               nh;
    logic                 oob;
    state_t               state;
    dir_t                 cur_dir, pend_dir;
    logic                 grow_pend, grow_step;
    logic [LEN_W-1:0]     idx, scan_n_q;
    logic [LEN_W-1:0]     scan_n;

    function automatic coord_t init_seg(int i);
        coord_t c;
        c.x = '0;
        c.y = '0;
        if (i < START_LEN) begin
            c.x = COORD_W'(START_LEN - 1 - i);
            c.y = COORD_W'(GRID_H / 2);
        end
        return c;
    endfunction

    // The pending direction is what becomes current at CALC, so it drives the next-head math.
    snake_next_head #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_next_head (
        .head          (seg[0]),
        .dir           (pend_dir),
        .next          (nh),
        .out_of_bounds (oob)
    );

    // Tail is skipped unless growing, since it vacates its tile on this step.
    always_comb begin
        scan_n = grow_pend ? length : (length - L_ONE);
    end

    for (genvar i = 0; i < MAX_LEN; i++) begin : g_out
        assign x_values[COORD_W*i +: COORD_W] = seg[i].x;
        assign y_values[COORD_W*i +: COORD_W] = seg[i].y;
    end

    // Step FSM with latches, body array and registered status outputs; restart outranks everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_LEN; i++) seg[i] <= init_seg(i);
            next_head <= '0;
            length    <= START_L;
            cur_dir   <= DIR_RIGHT;
            pend_dir  <= DIR_RIGHT;
            grow_pend <= 1'b0;
            grow_step <= 1'b0;
            idx       <= '0;
            scan_n_q  <= '0;
            busy      <= 1'b0;
            step_done <= 1'b0;
            game_over <= 1'b0;
            state     <= ST_IDLE;
        end else if (restart) begin
            for (int i = 0; i < MAX_LEN; i++) seg[i] <= init_seg(i);
            next_head <= '0;
            length    <= START_L;
            cur_dir   <= DIR_RIGHT;
            pend_dir  <= DIR_RIGHT;
            grow_pend <= 1'b0;
            grow_step <= 1'b0;
            idx       <= '0;
            scan_n_q  <= '0;
            busy      <= 1'b0;
            step_done <= 1'b0;
            game_over <= 1'b0;
            state     <= ST_IDLE;
        end else begin
            step_done <= 1'b0;
            if (dir_valid && (dir_t'(dir) != dir_opposite(cur_dir))) pend_dir <= dir_t'(dir);
            if (grow && (length != MAX_L)) grow_pend <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (tick) begin
                        busy  <= 1'b1;
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    cur_dir   <= pend_dir;
                    next_head <= nh;
                    grow_step <= grow_pend;
                    scan_n_q  <= scan_n;
                    idx       <= '0;
                    if (oob) begin
                        busy      <= 1'b0;
                        game_over <= 1'b1;
                        state     <= ST_OVER;
                    end else if (scan_n == '0) begin
                        state <= ST_COMMIT;
                    end else begin
                        state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (seg[idx] == next_head) begin
                        busy      <= 1'b0;
                        game_over <= 1'b1;
                        state     <= ST_OVER;
                    end else if (idx == scan_n_q - L_ONE) begin
                        state <= ST_COMMIT;
                    end else begin
                        idx <= idx + L_ONE;
                    end
                end
                ST_COMMIT: begin
                    for (int i = 1; i < MAX_LEN; i++) seg[i] <= seg[i-1];
                    seg[0] <= next_head;
                    if (grow_step && (length != MAX_L)) length <= length + L_ONE;
                    grow_pend <= 1'b0;
                    step_done <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                ST_OVER: begin
                    // frozen until restart or reset
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/snake_step_controller.md
# snake_step_controller

Sequences the snake body state that feeds `VGAController`'s `x_values`/`y_values` buses. On each game tick it computes the next head tile from the latched direction and checks it against the walls. It then scans the body for self-collision one segment per cycle, and commits a shift of all segments in one cycle, growing by one when a grow request is pending. Outputs are tile coordinates; pixel mapping stays in the VGA path.

## Interface
Parameters:
- `MAX_LEN`, 100: segment capacity; packed buses are `MAX_LEN*32` bits.
- `GRID_W`, 8: columns; legal x is 0..GRID_W-1.
- `GRID_H`, 8: rows; legal y is 0..GRID_H-1.
- `START_LEN`, 3: length after reset or restart, ≥2.

Ports:
- `clk`  in  1  system clock (100 MHz).
- `reset`  in  1  asynchronous, active-low reset.
- `tick`  in  1  one-cycle game-step request.
- `dir_valid`  in  1  qualifies `dir`.
- `dir`  in  2  requested direction: 00 up, 01 right, 10 down, 11 left.
- `grow`  in  1  pulse; the next committed step lengthens the snake.
- `restart`  in  1  synchronous re-initialise.
- `x_values`  out  MAX_LEN*32  segment i x at [32i+31:32i]; i=0 is the head.
- `y_values`  out  MAX_LEN*32  segment y, same packing.
- `length`  out  $clog2(MAX_LEN+1)  live segment count.
- `busy`  out  1  step in progress.
- `step_done`  out  1  one-cycle pulse; the outputs already hold the new state.
- `game_over`  out  1  sticky until restart or reset.

## Operation
- Reset and restart values (identical):
  - segment i = (START_LEN-1-i, GRID_H/2) for i<START_LEN; all other segments = (0,0).
  - `length`=START_LEN; current direction = right.
  - `busy`, `step_done`, `game_over` = 0; grow_pending = 0; pending direction = right.
- Direction latch (any state): `dir_valid` stores `dir` as pending, unless it is the exact opposite of the current direction. The pending direction becomes current at CALC.
- Grow latch (any state): `grow` sets grow_pending.
  - Cleared at COMMIT.
  - Ignored while `length`==MAX_LEN, so length saturates.
- FSM states: IDLE, CALC, SCAN, COMMIT, OVER.
  - IDLE: `tick` → CALC.
  - CALC: register next_head = head ± 1 on the current direction axis. Compute the scan count n = length-1, or length if grow_pending; the tail is excluded when it will vacate. Transitions:
    - next head out of bounds (x<0, x≥GRID_W, y<0, y≥GRID_H; signed compare on a 1-bit-extended value) → OVER.
    - otherwise n==0 → COMMIT, else SCAN with idx=0.
  - SCAN: compare next_head to segment idx, one segment per cycle.
    - match → OVER.
    - idx==n-1 → COMMIT.
    - otherwise idx+1.
  - COMMIT: segment[i] ← segment[i-1] for 1≤i<MAX_LEN, segment[0] ← next_head. If grow_pending, length+1. Then → IDLE.
  - OVER: `game_over`=1; arrays and length frozen; only `restart` exits.
- `tick` outside IDLE is dropped, not queued.
- `restart` has priority over every other event in the same cycle, in any state.
- Segments at index ≥ `length` carry stale shifted values; consumers must gate on `length`.

## Timing
- Edge E0 samples `tick` in IDLE → CALC.
- E1: CALC.
- E2..E(n+1): SCAN.
- E(n+2): COMMIT. The new arrays, length, and `step_done`=1 are visible for the cycle after E(n+2).
- Latency = n+2 edges after E0. Example: length 3, no grow → n=2 → 4 edges.
- `busy` is high from the cycle after E0 through the COMMIT cycle. `busy` is low in IDLE and OVER.
- `game_over` rises the cycle after the detecting edge (CALC or SCAN). `step_done` does not pulse on a failed step.
- Asserting `reset` mid-step aborts immediately to reset values.

## Structure
- Shared package `snake_pkg`:
  - direction encodings DIR_UP/RIGHT/DOWN/LEFT.
  - FSM state enum.
  - COORD_W=32.
  - TILE constants already used by the VGA path (board origin 48, tile 48).
- One sub-module `snake_next_head` (combinational): inputs head x/y and direction; outputs next x/y and an out_of_bounds flag.

## Test plan
- Reset: release `reset` → x_values[95:0] = {0,1,2}, y = 4,4,4, length=3, `busy`=0, `game_over`=0.
- Straight step: `tick` → `step_done` 4 edges later; head (3,4), segments (3,4),(2,4),(1,4); length 3.
- Reversal and grow:
  - `dir`=left while moving right → ignored.
  - `dir`=up, then `grow`, then `tick` → head (2,3), length 4, latency 5 edges.
- Wall: head at (7,4) moving right, `tick` → `game_over`=1 after CALC, arrays unchanged, no `step_done`. Later `tick`s are ignored; `restart` → reset values.
- Self-collision: length-5 body looped (up, left, down) → `game_over` raised during SCAN on the matching idx. Separately, head entering the vacating tail tile with no grow → legal step.
- Overlap events:
  - `tick` while `busy` → dropped; exactly one `step_done`.
  - `restart` coincident with COMMIT → reset values win.
  - `grow` at length MAX_LEN → length stays MAX_LEN.
